// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM states, responder
// word addresses, default expected words and small compare helpers.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    WT_ID = 3'd2,
    RD_TS = 3'd3,
    WT_TS = 3'd4,
    DONE  = 3'd5
  } sysid_state_e;

  localparam logic ID_ADDR = 1'b0;
  localparam logic TS_ADDR = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h58AB_BDA5;

  function automatic logic word_mismatch(input logic [31:0] seen, input logic [31:0] expected);
    return (seen != expected);
  endfunction

  function automatic logic in_txn(input sysid_state_e st);
    logic r;
    case (st)
      RD_ID, WT_ID, RD_TS, WT_TS: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_read_state(input sysid_state_e st);
    logic r;
    case (st)
      RD_ID, RD_TS: r = 1'b1;
      default:      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sysid_txn_timer.sv
// Per-transaction timeout counter: clear/load/enable, saturating count, and an
// expired flag raised in the last permitted cycle of a transaction.
module sysid_txn_timer
  import sysid_pkg::*;
#(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_r;

  // Count enabled cycles since the last clear, holding at the top value.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // The edge closing this cycle would complete LIMIT enabled cycles.
  assign expired = enable & (count_r >= LAST);

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Avalon-MM master that reads the system-ID responder and flags mismatches.
// Define SYSID_CHECK_TS_EN to also read and compare the timestamp word.
module niosii_system_sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_seen,
  output logic [31:0] ts_seen
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef SYSID_CHECK_TS_EN
  localparam sysid_state_e AFTER_ID = RD_TS;
`else
  localparam sysid_state_e AFTER_ID = DONE;
  logic [32:0] ts_unused_s;
  assign ts_unused_s = {TS_ADDR, EXPECTED_TS};
`endif

  sysid_state_e state_r, state_s;

  logic        start_r;
  logic        start_ok_s, restart_s, accepted_s, complete_s;
  logic        expired_s, timeout_evt_s, tmr_clear_s, tmr_enable_s;
  logic        avm_read_r, avm_address_r, busy_r, done_r, pass_r;
  logic        id_mm_r, ts_mm_r, timeout_r;
  logic        id_mm_s, ts_mm_s, timeout_s, pass_s;
  logic [31:0] id_seen_r, ts_seen_r, id_seen_s, ts_seen_s;

  assign start_ok_s    = (state_r == IDLE) || (state_r == DONE);
  assign restart_s     = start_ok_s && (state_s == RD_ID);
  assign accepted_s    = avm_read_r & ~avm_waitrequest;
  assign complete_s    = ((state_r == WT_ID) || (state_r == WT_TS)) && avm_readdatavalid;
  assign timeout_evt_s = expired_s & ~complete_s;
  assign tmr_enable_s  = in_txn(state_r);
  assign tmr_clear_s   = is_read_state(state_s) && (state_s != state_r);

  sysid_txn_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (tmr_clear_s),
    .load       (1'b0),
    .load_value ({CNT_W{1'b0}}),
    .enable     (tmr_enable_s),
    .expired    (expired_s)
  );

  // Next-state decode; an expiring timer wins over a same-cycle command accept,
  // but a response arriving in the last permitted cycle still counts.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start_r) state_s = RD_ID;
        else         state_s = state_r;
      end
      RD_ID: begin
        if (expired_s)       state_s = DONE;
        else if (accepted_s) state_s = WT_ID;
        else                 state_s = RD_ID;
      end
      WT_ID: begin
        if (avm_readdatavalid) state_s = AFTER_ID;
        else if (expired_s)    state_s = DONE;
        else                   state_s = WT_ID;
      end
`ifdef SYSID_CHECK_TS_EN
      RD_TS: begin
        if (expired_s)       state_s = DONE;
        else if (accepted_s) state_s = WT_TS;
        else                 state_s = RD_TS;
      end
      WT_TS: begin
        if (avm_readdatavalid) state_s = DONE;
        else if (expired_s)    state_s = DONE;
        else                   state_s = WT_TS;
      end
`endif
      default: state_s = IDLE;
    endcase
  end

  // Next values of the result registers: capture, compare, timeout and verdict.
  always_comb begin
    id_seen_s = id_seen_r;
    id_mm_s   = id_mm_r;
    ts_seen_s = ts_seen_r;
    ts_mm_s   = ts_mm_r;
    timeout_s = timeout_r;
    pass_s    = pass_r;
    if (restart_s) begin
      id_seen_s = 32'h0000_0000;
      id_mm_s   = 1'b0;
      ts_seen_s = 32'h0000_0000;
      ts_mm_s   = 1'b0;
      timeout_s = 1'b0;
      pass_s    = 1'b0;
    end else begin
      if ((state_r == WT_ID) && avm_readdatavalid) begin
        id_seen_s = avm_readdata;
        id_mm_s   = word_mismatch(avm_readdata, EXPECTED_ID);
      end else begin
        id_seen_s = id_seen_r;
        id_mm_s   = id_mm_r;
      end
`ifdef SYSID_CHECK_TS_EN
      if ((state_r == WT_TS) && avm_readdatavalid) begin
        ts_seen_s = avm_readdata;
        ts_mm_s   = word_mismatch(avm_readdata, EXPECTED_TS);
      end else begin
        ts_seen_s = ts_seen_r;
        ts_mm_s   = ts_mm_r;
      end
`endif
      if (timeout_evt_s) timeout_s = 1'b1;
      else               timeout_s = timeout_r;
      if ((state_s == DONE) && (state_r != DONE)) pass_s = ~timeout_s & ~id_mm_s & ~ts_mm_s;
      else                                        pass_s = pass_r;
    end
  end

  // State and every output are registered; Avalon outputs follow the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      start_r       <= 1'b0;
      avm_read_r    <= 1'b0;
      avm_address_r <= ID_ADDR;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      id_mm_r       <= 1'b0;
      ts_mm_r       <= 1'b0;
      timeout_r     <= 1'b0;
      id_seen_r     <= 32'h0000_0000;
      ts_seen_r     <= 32'h0000_0000;
    end else begin
      state_r       <= state_s;
      start_r       <= start & start_ok_s;
      avm_read_r    <= is_read_state(state_s);
      avm_address_r <= (state_s == RD_TS) ? TS_ADDR : ID_ADDR;
      busy_r        <= in_txn(state_s);
      done_r        <= (state_s == DONE);
      pass_r        <= pass_s;
      id_mm_r       <= id_mm_s;
      ts_mm_r       <= ts_mm_s;
      timeout_r     <= timeout_s;
      id_seen_r     <= id_seen_s;
      ts_seen_r     <= ts_seen_s;
    end
  end

  assign avm_read    = avm_read_r;
  assign avm_address = avm_address_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign id_mismatch = id_mm_r;
  assign ts_mismatch = ts_mm_r;
  assign timeout     = timeout_r;
  assign id_seen     = id_seen_r;
  assign ts_seen     = ts_seen_r;

endmodule
